// File: rtl/bfm_pkg.sv
// Shared encodings for the receive/transmit BFMs: FSM states, pause modes, LFSR taps
// and the pause-length selection used on every accepted word.
package bfm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RCVD = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] PM_NONE  = 2'd0;
  localparam logic [1:0] PM_FIXED = 2'd1;
  localparam logic [1:0] PM_RAND  = 2'd2;

  // Taps 16,14,13,11 as bit positions 15,13,12,10 of a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Random mode draws 0..bound inclusive; bound+1 needs 33 bits when bound is all ones
  function automatic logic [31:0] pause_sel(input logic [1:0]  mode,
                                            input logic [31:0] bound,
                                            input logic [15:0] lfsr);
    logic [32:0] modulus;
    modulus   = {1'b0, bound} + 33'd1;
    pause_sel = '0;
    case (mode)
      PM_NONE:  pause_sel = '0;
      PM_FIXED: pause_sel = bound;
      PM_RAND:  pause_sel = 32'({17'd0, lfsr} % modulus);
      default:  pause_sel = '0;
    endcase
  endfunction

endpackage

// File: rtl/bfm_lfsr16.sv
// 16-bit Fibonacci LFSR, one step per adv; shared by the receive and transmit BFMs.
// Latency: q updates on the edge where adv is high; reset loads seed (must be nonzero).
module bfm_lfsr16
  import bfm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= seed;
    end else if (adv) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/bfm_rcvr_cap.sv
// Receive BFM: sinks a valid/ready stream into a DEPTH-entry capture buffer, rx_rdy is a
// registered Moore output with LFSR-driven pauses. BFM_RCVR_CHECK_EN adds exp_data checking.
module bfm_rcvr_cap
  import bfm_pkg::*;
#(
  parameter int          DW        = 128,
  parameter int          DEPTH     = 16,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter string       NAME      = "Receiver"
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_vld,
  output logic          rx_rdy,
  output logic          rx_busy,
  output logic          rx_done,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   cfg_length,
  input  logic [31:0]   cfg_wait,
  input  logic [1:0]    cfg_pause_mode,
  input  logic [31:0]   cfg_pause_cycle,
  output logic [31:0]   rx_cnt,
  input  logic [AW-1:0] cap_rd_addr,
  output logic [DW-1:0] cap_rd_data,
  output logic          cap_ovf
`ifdef BFM_RCVR_CHECK_EN
  ,
  input  logic [DW-1:0] exp_data,
  output logic [31:0]   err_cnt,
  output logic          err_flag
`endif
);

  state_t        state, state_nxt;
  logic [31:0]   cnt_q, cnt_nxt;
  logic          done_nxt;
  logic          fin;
  logic [31:0]   len_q, wait_q, pcyc_q;
  logic [1:0]    pmode_q;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   lfsr_q;
  logic [DW-1:0] mem [DEPTH];

  logic          xfer;
  logic          start_idle;
  logic          abort_hit;
  logic          last_word;
  logic [31:0]   pause_p;

  assign rx_rdy      = (state == ST_RCVD);
  assign rx_busy     = (state != ST_IDLE);
  assign xfer        = rx_vld && rx_rdy;
  assign start_idle  = start && (state == ST_IDLE);
  assign abort_hit   = abort && (state != ST_IDLE);
  assign last_word   = (len_q != '0) && ((rx_cnt + 32'd1) == len_q);
  assign pause_p     = pause_sel(pmode_q, pcyc_q, lfsr_q);
  assign cap_rd_data = mem[cap_rd_addr];

  bfm_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .adv   (xfer),
    .q     (lfsr_q)
  );

  // cnt_q is a shared down-counter: wait cycles in WAIT, pause cycles in HOLD
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    done_nxt  = 1'b0;
    fin       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_wait != '0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = cfg_wait - 32'd1;
          end else begin
            state_nxt = ST_RCVD;
          end
        end
      end
      ST_WAIT, ST_HOLD: begin
        if (cnt_q == '0) state_nxt = ST_RCVD;
        else             cnt_nxt   = cnt_q - 32'd1;
      end
      ST_RCVD: begin
        if (xfer) begin
          if (last_word) begin
            state_nxt = ST_IDLE;
            fin       = 1'b1;
            done_nxt  = 1'b1;
          end else if (pause_p != '0) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = pause_p - 32'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = ST_IDLE;
      done_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      rx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt_q   <= cnt_nxt;
      rx_done <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      wait_q  <= '0;
      pcyc_q  <= '0;
      pmode_q <= PM_NONE;
      rx_cnt  <= '0;
      cap_ovf <= 1'b0;
      wr_ptr  <= '0;
    end else if (start_idle) begin
      len_q   <= cfg_length;
      wait_q  <= cfg_wait;
      pcyc_q  <= cfg_pause_cycle;
      pmode_q <= cfg_pause_mode;
      rx_cnt  <= '0;
      cap_ovf <= 1'b0;
      wr_ptr  <= '0;
    end else if (xfer) begin
      if (rx_cnt != '1) rx_cnt <= rx_cnt + 32'd1;
      if (rx_cnt >= 32'(DEPTH)) cap_ovf <= 1'b1;
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Capture storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr] <= rx_data;
  end

`ifdef BFM_RCVR_CHECK_EN
  logic data_bad;
  assign data_bad = xfer && (rx_data != exp_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (start_idle) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (data_bad) begin
      if (err_cnt != '1) err_cnt <= err_cnt + 32'd1;
      err_flag <= 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      if (start_idle)
        $display("[%s] start: length=%0d wait=%0d pause_mode=%0d pause_cycle=%0d",
                 NAME, cfg_length, cfg_wait, cfg_pause_mode, cfg_pause_cycle);
      if (abort_hit)
        $display("[%s] abort: %0d words received", NAME, rx_cnt + {31'd0, xfer});
      else if (fin)
        $display("[%s] done: %0d words received (wait %0d)", NAME, rx_cnt + 32'd1, wait_q);
`ifdef BFM_RCVR_CHECK_EN
      if (data_bad)
        $display("[%s] data compare: word %0d received %h expected %h",
                 NAME, rx_cnt, rx_data, exp_data);
`endif
    end
  end
`endif

endmodule
